// File: rtl/alu_seq.sv
// alu_seq: three-state micro-sequencer that drives an external 8-bit ALU.
// Owns a small register file and the architectural cf/zf flags. It accepts
// one instruction per valid/ready handshake and writes the result back two
// cycles after the instruction is accepted.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       opcode,
    input  logic [AW-1:0]    rd,
    input  logic [AW-1:0]    rs,
    input  logic [WIDTH-1:0] imm,
    output logic             alu_m,
    output logic [3:0]       alu_s,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_t,
    input  logic             alu_cf,
    input  logic             alu_zf,
    output logic             done,
    output logic             err,
    output logic             cf,
    output logic             zf,
    input  logic [AW-1:0]    dbg_sel,
    output logic [WIDTH-1:0] dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_MOV = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_AND = 3'b100,
        OP_NOT = 3'b101,
        OP_LDI = 3'b110,
        OP_RSV = 3'b111
    } op_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_regs [0:(1<<AW)-1];
    logic             r_cf;
    logic             r_zf;
    logic             r_alu_m;
    logic [3:0]       r_alu_s;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    op_t              r_op;
    logic [AW-1:0]    r_rd;
    logic [WIDTH-1:0] r_res;
    logic             r_res_cf;
    logic             r_res_zf;
    logic             r_done;
    logic             r_err;

    logic             w_m;
    logic [3:0]       w_s;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_wr;
    logic             w_flag_wr;

    // Decode the incoming opcode into the ALU control word and operands.
    always_comb begin
        w_m = 1'b0;
        w_s = 4'b0000;
        w_a = r_regs[rs];
        w_b = r_regs[rd];
        case (op_t'(opcode))
            OP_MOV: begin w_m = 1'b0; w_s = 4'b1100; end
            OP_ADD: begin w_m = 1'b1; w_s = 4'b1001; end
            OP_SUB: begin w_m = 1'b1; w_s = 4'b0110; end
            OP_AND: begin w_m = 1'b1; w_s = 4'b1011; end
            OP_NOT: begin w_m = 1'b1; w_s = 4'b0101; end
            OP_LDI: begin w_m = 1'b0; w_s = 4'b1100; w_a = imm; end
            default: begin w_m = 1'b0; w_s = 4'b0000; end
        endcase
    end

    // Decide which retiring instructions write the register file and flags.
    always_comb begin
        w_wr      = 1'b0;
        w_flag_wr = 1'b0;
        case (r_op)
            OP_MOV, OP_AND, OP_NOT, OP_LDI: w_wr = 1'b1;
            OP_ADD, OP_SUB: begin w_wr = 1'b1; w_flag_wr = 1'b1; end
            default: begin w_wr = 1'b0; w_flag_wr = 1'b0; end
        endcase
    end

    // Sequencer FSM: accept in IDLE, capture ALU result in EXEC, retire in WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            for (int unsigned i = 0; i < (1 << AW); i++) begin
                r_regs[AW'(i)] <= '0;
            end
            r_cf     <= 1'b0;
            r_zf     <= 1'b0;
            r_alu_m  <= 1'b0;
            r_alu_s  <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_op     <= OP_NOP;
            r_rd     <= '0;
            r_res    <= '0;
            r_res_cf <= 1'b0;
            r_res_zf <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_alu_m <= w_m;
                        r_alu_s <= w_s;
                        r_alu_a <= w_a;
                        r_alu_b <= w_b;
                        r_op    <= op_t'(opcode);
                        r_rd    <= rd;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_res    <= alu_t;
                    r_res_cf <= alu_cf;
                    r_res_zf <= alu_zf;
                    r_done   <= 1'b1;
                    r_err    <= (r_op == OP_RSV);
                    r_state  <= S_WB;
                end
                S_WB: begin
                    if (w_wr) begin
                        r_regs[r_rd] <= r_res;
                    end
                    if (w_flag_wr) begin
                        r_cf <= r_res_cf;
                        r_zf <= r_res_zf;
                    end
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_alu_m <= 1'b0;
                    r_alu_s <= '0;
                    r_alu_a <= '0;
                    r_alu_b <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign instr_ready = (r_state == S_IDLE);
    assign alu_m       = r_alu_m;
    assign alu_s       = r_alu_s;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign done        = r_done;
    assign err         = r_err;
    assign cf          = r_cf;
    assign zf          = r_zf;
    assign dbg_data    = r_regs[dbg_sel];

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq with a behavioural ALU attached.
module tb_alu_seq;

    logic       clk;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] opcode;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] imm;
    logic       alu_m;
    logic [3:0] alu_s;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_t;
    logic       alu_cf;
    logic       alu_zf;
    logic       done;
    logic       err;
    logic       cf;
    logic       zf;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;

    int checks = 0;
    int errors = 0;

    logic [8:0] alu_w;

    alu_seq #(.WIDTH(8), .AW(2)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .rd(rd), .rs(rs), .imm(imm),
        .alu_m(alu_m), .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b),
        .alu_t(alu_t), .alu_cf(alu_cf), .alu_zf(alu_zf),
        .done(done), .err(err), .cf(cf), .zf(zf),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: 9-bit add/sub so bit 8 is carry/borrow.
    always_comb begin
        alu_w = '0;
        case ({alu_m, alu_s})
            5'b0_1100: alu_w = {1'b0, alu_a};
            5'b1_1001: alu_w = {1'b0, alu_a} + {1'b0, alu_b};
            5'b1_0110: alu_w = {1'b0, alu_b} - {1'b0, alu_a};
            5'b1_1011: alu_w = {1'b0, alu_a & alu_b};
            5'b1_0101: alu_w = {1'b0, ~alu_b};
            default:   alu_w = '0;
        endcase
    end
    assign alu_t  = alu_w[7:0];
    assign alu_cf = alu_w[8];
    assign alu_zf = (alu_w[7:0] == 8'h00);

    initial begin
        #200000;
        $display("FAIL watchdog sim time exceeded");
        $fatal(1);
    end

    // Present one instruction in an IDLE cycle; returns 1ns after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [1:0] d, input logic [1:0] s,
                         input logic [7:0] im);
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (!instr_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            checks++; errors++;
            $display("FAIL issue_timeout instr_ready got %b want 1", instr_ready);
        end
        opcode = op; rd = d; rs = s; imm = im; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        opcode = 3'b111; rd = ~d; rs = ~s; imm = ~im;
    endtask

    // From 1ns after accept, advance through WB to 1ns into the next IDLE cycle.
    task automatic finish_instr();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", instr_ready); end
        checks++; if (cf !== 1'b0) begin errors++; $display("FAIL reset_cf got %b want 0", cf); end
        checks++; if (zf !== 1'b0) begin errors++; $display("FAIL reset_zf got %b want 0", zf); end
        checks++; if (alu_m !== 1'b0) begin errors++; $display("FAIL reset_alu_m got %b want 0", alu_m); end
        checks++; if (alu_s !== 4'b0000) begin errors++; $display("FAIL reset_alu_s got %b want 0000", alu_s); end
        checks++; if (alu_a !== 8'h00 || alu_b !== 8'h00) begin errors++; $display("FAIL reset_alu_ab got %h/%h want 00/00", alu_a, alu_b); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_done_err got %b/%b want 0/0", done, err); end
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #0.5;
            checks++; if (dbg_data !== 8'h00) begin errors++; $display("FAIL reset_reg%0d got %h want 00", i, dbg_data); end
        end
    endtask

    task automatic test_add_overflow();
        issue(3'b110, 2'd0, 2'd0, 8'h80); finish_instr();
        issue(3'b110, 2'd1, 2'd0, 8'h80); finish_instr();
        issue(3'b010, 2'd1, 2'd0, 8'h00);
        checks++; if (alu_m !== 1'b1 || alu_s !== 4'b1001) begin errors++; $display("FAIL add_ctrl got m%b s%b want m1 s1001", alu_m, alu_s); end
        checks++; if (alu_a !== 8'h80 || alu_b !== 8'h80) begin errors++; $display("FAIL add_operands got %h/%h want 80/80", alu_a, alu_b); end
        checks++; if (instr_ready !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL add_exec_ready_done got %b/%b want 0/0", instr_ready, done); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL add_wb_done_err got %b/%b want 1/0", done, err); end
        checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL add_wb_ready got %b want 0", instr_ready); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || instr_ready !== 1'b1) begin errors++; $display("FAIL add_idle_done_ready got %b/%b want 0/1", done, instr_ready); end
        checks++; if (cf !== 1'b1 || zf !== 1'b1) begin errors++; $display("FAIL add_flags got cf%b zf%b want cf1 zf1", cf, zf); end
        checks++; if (alu_m !== 1'b0 || alu_s !== 4'b0000 || alu_a !== 8'h00) begin errors++; $display("FAIL add_alu_release got m%b s%b a%h want m0 s0000 a00", alu_m, alu_s, alu_a); end
        dbg_sel = 2'd1; #0.5;
        checks++; if (dbg_data !== 8'h00) begin errors++; $display("FAIL add_result got %h want 00", dbg_data); end
    endtask

    task automatic test_flag_preserve();
        issue(3'b100, 2'd0, 2'd0, 8'h00); finish_instr();
        dbg_sel = 2'd0; #0.5;
        checks++; if (dbg_data !== 8'h80) begin errors++; $display("FAIL and_result got %h want 80", dbg_data); end
        checks++; if (cf !== 1'b1 || zf !== 1'b1) begin errors++; $display("FAIL and_flags got cf%b zf%b want cf1 zf1", cf, zf); end
        issue(3'b101, 2'd0, 2'd0, 8'h00);
        checks++; if (alu_m !== 1'b1 || alu_s !== 4'b0101 || alu_b !== 8'h80) begin errors++; $display("FAIL not_ctrl got m%b s%b b%h want m1 s0101 b80", alu_m, alu_s, alu_b); end
        finish_instr();
        dbg_sel = 2'd0; #0.5;
        checks++; if (dbg_data !== 8'h7F) begin errors++; $display("FAIL not_result got %h want 7f", dbg_data); end
        checks++; if (cf !== 1'b1 || zf !== 1'b1) begin errors++; $display("FAIL not_flags got cf%b zf%b want cf1 zf1", cf, zf); end
        issue(3'b001, 2'd2, 2'd0, 8'h00); finish_instr();
        dbg_sel = 2'd2; #0.5;
        checks++; if (dbg_data !== 8'h7F) begin errors++; $display("FAIL mov_result got %h want 7f", dbg_data); end
        checks++; if (cf !== 1'b1 || zf !== 1'b1) begin errors++; $display("FAIL mov_flags got cf%b zf%b want cf1 zf1", cf, zf); end
    endtask

    task automatic test_sub_borrow();
        issue(3'b110, 2'd2, 2'd0, 8'h05); finish_instr();
        issue(3'b110, 2'd3, 2'd0, 8'h03); finish_instr();
        issue(3'b011, 2'd3, 2'd2, 8'h00);
        checks++; if (alu_m !== 1'b1 || alu_s !== 4'b0110 || alu_a !== 8'h05 || alu_b !== 8'h03) begin
            errors++; $display("FAIL sub_exec got m%b s%b a%h b%h want m1 s0110 a05 b03", alu_m, alu_s, alu_a, alu_b); end
        finish_instr();
        dbg_sel = 2'd3; #0.5;
        checks++; if (dbg_data !== 8'hFE) begin errors++; $display("FAIL sub_borrow_result got %h want fe", dbg_data); end
        checks++; if (cf !== 1'b1 || zf !== 1'b0) begin errors++; $display("FAIL sub_borrow_flags got cf%b zf%b want cf1 zf0", cf, zf); end
        issue(3'b011, 2'd2, 2'd2, 8'h00); finish_instr();
        dbg_sel = 2'd2; #0.5;
        checks++; if (dbg_data !== 8'h00) begin errors++; $display("FAIL sub_self_result got %h want 00", dbg_data); end
        checks++; if (cf !== 1'b0 || zf !== 1'b1) begin errors++; $display("FAIL sub_self_flags got cf%b zf%b want cf0 zf1", cf, zf); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops  [3];
        logic [1:0] rds  [3];
        logic [7:0] imms [3];
        logic [8:0] ready_v;
        logic [8:0] done_v;
        int idx;
        logic prev_acc;
        ops  = '{3'b110, 3'b110, 3'b010};
        rds  = '{2'd0, 2'd1, 2'd1};
        imms = '{8'h11, 8'h22, 8'h00};
        ready_v = '0; done_v = '0; idx = 0; prev_acc = 1'b0;
        @(negedge clk);
        opcode = ops[0]; rd = rds[0]; rs = 2'd0; imm = imms[0]; instr_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            if (prev_acc) begin
                idx++;
                if (idx < 3) begin
                    opcode = ops[idx]; rd = rds[idx]; rs = 2'd0; imm = imms[idx];
                end else begin
                    opcode = 3'b111; rd = 2'd3; rs = 2'd3; imm = 8'hA5;
                end
            end
            ready_v[i] = instr_ready;
            done_v[i]  = done;
            prev_acc   = instr_ready;
        end
        instr_valid = 1'b0;
        checks++; if (ready_v !== 9'b001_001_001) begin errors++; $display("FAIL b2b_ready_pattern got %b want 001001001", ready_v); end
        checks++; if (done_v !== 9'b100_100_100) begin errors++; $display("FAIL b2b_done_pattern got %b want 100100100", done_v); end
        @(posedge clk); #1;
        dbg_sel = 2'd0; #0.5;
        checks++; if (dbg_data !== 8'h11) begin errors++; $display("FAIL b2b_r0 got %h want 11", dbg_data); end
        dbg_sel = 2'd1; #0.5;
        checks++; if (dbg_data !== 8'h33) begin errors++; $display("FAIL b2b_r1 got %h want 33", dbg_data); end
        checks++; if (cf !== 1'b0 || zf !== 1'b0) begin errors++; $display("FAIL b2b_flags got cf%b zf%b want cf0 zf0", cf, zf); end
        checks++; if (instr_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_idle got ready%b done%b want ready1 done0", instr_ready, done); end
    endtask

    task automatic test_reserved();
        issue(3'b111, 2'd1, 2'd0, 8'hFF);
        checks++; if (done !== 1'b0 || alu_m !== 1'b0 || alu_s !== 4'b0000) begin errors++; $display("FAIL rsv_exec got done%b m%b s%b want done0 m0 s0000", done, alu_m, alu_s); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL rsv_wb got done%b err%b want done1 err1", done, err); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rsv_after got done%b err%b want done0 err0", done, err); end
        dbg_sel = 2'd1; #0.5;
        checks++; if (dbg_data !== 8'h33) begin errors++; $display("FAIL rsv_no_write got %h want 33", dbg_data); end
        checks++; if (cf !== 1'b0 || zf !== 1'b0) begin errors++; $display("FAIL rsv_flags got cf%b zf%b want cf0 zf0", cf, zf); end
    endtask

    task automatic test_reset_midop();
        issue(3'b010, 2'd1, 2'd0, 8'h00);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_no_done got %b want 0", done); end
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", instr_ready); end
        checks++; if (cf !== 1'b0 || zf !== 1'b0) begin errors++; $display("FAIL midrst_flags got cf%b zf%b want cf0 zf0", cf, zf); end
        dbg_sel = 2'd1; #0.5;
        checks++; if (dbg_data !== 8'h00) begin errors++; $display("FAIL midrst_r1 got %h want 00", dbg_data); end
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_hold_done got %b want 0", done); end
        issue(3'b110, 2'd2, 2'd0, 8'h5A);
        @(posedge clk); #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL postrst_done got %b want 1", done); end
        @(posedge clk); #1;
        dbg_sel = 2'd2; #0.5;
        checks++; if (dbg_data !== 8'h5A) begin errors++; $display("FAIL postrst_r2 got %h want 5a", dbg_data); end
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; opcode = 3'b000; rd = 2'd0; rs = 2'd0;
        imm = 8'h00; dbg_sel = 2'd0;
        test_reset();
        test_add_overflow();
        test_flag_preserve();
        test_sub_borrow();
        test_back_to_back();
        test_reserved();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
